// File: rtl/bcd_to_binary_serial_if.sv
// Handshake/data bundle between a digit-entry front end and the BCD-to-binary converter.
// Latency: n/a (wires only).
// Backpressure: none; the master watches o_Busy and o_Done.
//
// Ports (master view):
//   i_Start    out  pulse to request a conversion of i_BCD
//   i_BCD      out  packed BCD, digit DECIMAL_DIGITS-1 most significant
//   o_Busy     in   conversion in progress
//   o_Done     in   one-cycle pulse, result and flags valid
//   o_Binary   in   converted value, held until the next o_Done
//   o_Invalid  in   last conversion saw a digit > 9
//   o_Overflow in   last result did not fit in OUTPUT_WIDTH bits
interface bcd_to_binary_serial_if #(
  parameter int DECIMAL_DIGITS = 2,
  parameter int OUTPUT_WIDTH   = 7
);
  logic                        i_Start;
  logic [DECIMAL_DIGITS*4-1:0] i_BCD;
  logic                        o_Busy;
  logic                        o_Done;
  logic [OUTPUT_WIDTH-1:0]     o_Binary;
  logic                        o_Invalid;
  logic                        o_Overflow;

  modport master (
    output i_Start, i_BCD,
    input  o_Busy, o_Done, o_Binary, o_Invalid, o_Overflow
  );

  modport slave (
    input  i_Start, i_BCD,
    output o_Busy, o_Done, o_Binary, o_Invalid, o_Overflow
  );
endinterface

// File: rtl/bcd_to_binary_serial.sv
// Serial packed-BCD to unsigned binary converter, one digit per clock, MSD first (acc = acc*10 + d).
// Latency: o_Done pulses DECIMAL_DIGITS cycles after the edge that accepts i_Start.
// Backpressure: none; i_Start is ignored while busy, accepted again in the o_Done cycle.
//
// Ports:
//   i_Clock  rising-edge clock
//   i_Rst_L  asynchronous active-low reset; aborts any conversion without o_Done
//   bus      slave side of bcd_to_binary_serial_if (i_Start/i_BCD in; o_Busy/o_Done/o_Binary/o_Invalid/o_Overflow out)
module bcd_to_binary_serial #(
  parameter int DECIMAL_DIGITS = 2,
  parameter int OUTPUT_WIDTH   = 7
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_L,
  bcd_to_binary_serial_if.slave bus
);

  // Bits needed for the largest value the accumulator can reach: every digit
  // at 15, so invalid input can never wrap the accumulator.
  function automatic int calc_acc_w();
    longint unsigned m;
    int              w;
    m = 0;
    w = 0;
    for (int k = 0; k < DECIMAL_DIGITS; k++) begin
      m = m * 10 + 15;
    end
    while (m != 0) begin
      w++;
      m = m >> 1;
    end
    return w;
  endfunction

  localparam int ACC_RAW = calc_acc_w();
  // Keep at least one bit above the output so overflow is a simple OR of the top bits.
  localparam int ACC_W   = (ACC_RAW > OUTPUT_WIDTH) ? ACC_RAW : OUTPUT_WIDTH + 1;
  localparam int DW      = DECIMAL_DIGITS * 4;
  localparam int CNT_W   = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DECIMAL_DIGITS - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  state_t                  r_state;
  logic [DW-1:0]           r_digits;
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_inv;
  logic                    r_ovf;
  logic                    r_busy;
  logic                    r_done;
  logic [OUTPUT_WIDTH-1:0] r_binary;
  logic                    r_invalid;
  logic                    r_overflow;

  logic [3:0]       w_digit;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_digit_bad;
  logic             w_acc_big;
  logic             w_inv_all;
  logic             w_ovf_all;
  logic             w_last;

  // The digit being consumed is always the top nibble; the register shifts left.
  assign w_digit     = r_digits[DW-1 -: 4];
  assign w_acc_next  = r_acc * ACC_W'(10) + ACC_W'(w_digit);
  assign w_digit_bad = (w_digit > 4'd9);
  assign w_acc_big   = |w_acc_next[ACC_W-1:OUTPUT_WIDTH];
  // Sticky values including the digit processed this cycle, for the final edge.
  assign w_inv_all   = r_inv | w_digit_bad;
  assign w_ovf_all   = r_ovf | w_acc_big;
  assign w_last      = (r_cnt == '0);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= S_IDLE;
      r_digits   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_inv      <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_binary   <= '0;
      r_invalid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.i_Start) begin
            r_digits <= bus.i_BCD;
            r_acc    <= '0;
            r_inv    <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= CNT_LOAD;
            r_busy   <= 1'b1;
            r_state  <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_acc    <= w_acc_next;
          r_digits <= r_digits << 4;
          r_inv    <= w_inv_all;
          r_ovf    <= w_ovf_all;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (w_last) begin
            // Invalid input wins: report a clean zero rather than a garbage value.
            if (w_inv_all) begin
              r_binary   <= '0;
              r_invalid  <= 1'b1;
              r_overflow <= 1'b0;
            end else begin
              r_binary   <= w_acc_next[OUTPUT_WIDTH-1:0];
              r_invalid  <= 1'b0;
              r_overflow <= w_ovf_all;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_Busy     = r_busy;
  assign bus.o_Done     = r_done;
  assign bus.o_Binary   = r_binary;
  assign bus.o_Invalid  = r_invalid;
  assign bus.o_Overflow = r_overflow;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Self-checking bench for bcd_to_binary_serial: three instances (2 digits/7 bits,
// 2 digits/6 bits, 1 digit/4 bits) checked against a positional-sum reference model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bcd_to_binary_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] last_bin [3];

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       inv;
    logic       ovf;
    logic [7:0] bin;
  } obs_t;

  bcd_to_binary_serial_if #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) ifa ();
  bcd_to_binary_serial_if #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(6)) ifb ();
  bcd_to_binary_serial_if #(.DECIMAL_DIGITS(1), .OUTPUT_WIDTH(4)) ifc ();

  bcd_to_binary_serial #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(7)) u_a (.i_Clock(clk), .i_Rst_L(rst_n), .bus(ifa));
  bcd_to_binary_serial #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(6)) u_b (.i_Clock(clk), .i_Rst_L(rst_n), .bus(ifb));
  bcd_to_binary_serial #(.DECIMAL_DIGITS(1), .OUTPUT_WIDTH(4)) u_c (.i_Clock(clk), .i_Rst_L(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int digs(input int sel);
    return (sel == 2) ? 1 : 2;
  endfunction

  function automatic int wid(input int sel);
    return (sel == 0) ? 7 : ((sel == 1) ? 6 : 4);
  endfunction

  // Reference: value = sum of digit_k * 10^k; invalid beats overflow.
  task automatic ref_conv(input int sel, input logic [31:0] bcd,
                          output logic [7:0] bin, output logic inv, output logic ovf);
    longint v;
    longint p;
    longint lim;
    int     d;
    v   = 0;
    p   = 1;
    inv = 1'b0;
    lim = longint'(1) << wid(sel);
    for (int k = 0; k < digs(sel); k++) begin
      d = int'((bcd >> (4 * k)) & 32'hF);
      if (d > 9) inv = 1'b1;
      v = v + longint'(d) * p;
      p = p * 10;
    end
    if (inv) begin
      bin = 8'd0;
      ovf = 1'b0;
    end else if (v >= lim) begin
      bin = 8'(v % lim);
      ovf = 1'b1;
    end else begin
      bin = 8'(v);
      ovf = 1'b0;
    end
  endtask

  task automatic set_in(input int sel, input logic s, input logic [31:0] bcd);
    case (sel)
      0: begin ifa.i_Start = s; ifa.i_BCD = bcd[7:0]; end
      1: begin ifb.i_Start = s; ifb.i_BCD = bcd[7:0]; end
      default: begin ifc.i_Start = s; ifc.i_BCD = bcd[3:0]; end
    endcase
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    case (sel)
      0: o = '{ifa.o_Busy, ifa.o_Done, ifa.o_Invalid, ifa.o_Overflow, {1'b0, ifa.o_Binary}};
      1: o = '{ifb.o_Busy, ifb.o_Done, ifb.o_Invalid, ifb.o_Overflow, {2'b0, ifb.o_Binary}};
      default: o = '{ifc.o_Busy, ifc.o_Done, ifc.o_Invalid, ifc.o_Overflow, {4'b0, ifc.o_Binary}};
    endcase
    return o;
  endfunction

  // Called at a falling edge; returns at the falling edge where o_Done is seen
  // (or after a bounded wait). lat counts rising edges after the start edge.
  task automatic do_conv(input int sel, input logic [31:0] bcd, output int lat,
                         output int busy_cnt, output logic [7:0] held, output obs_t res);
    obs_t o;
    set_in(sel, 1'b1, bcd);
    @(negedge clk);
    set_in(sel, 1'b0, $urandom);   // scramble i_BCD after capture
    o        = get_obs(sel);
    held     = o.bin;
    lat      = 0;
    busy_cnt = 0;
    while (!o.done && lat < 50) begin
      if (o.busy) busy_cnt++;
      @(negedge clk);
      lat++;
      o = get_obs(sel);
    end
    res = o;
  endtask

  task automatic test_reset;
    obs_t o;
    for (int s = 0; s < 3; s++) begin
      o = get_obs(s);
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got=%h want=0", s, o);
      end
    end
  endtask

  task automatic test_defaults;
    int lat, bc;
    logic [7:0] held;
    obs_t r;
    do_conv(0, 32'h42, lat, bc, held, r);
    checks++; if (lat !== 2) begin errors++; $display("FAIL default_latency got=%0d want=2", lat); end
    checks++; if (bc !== 2) begin errors++; $display("FAIL default_busy_cycles got=%0d want=2", bc); end
    checks++; if (r.bin !== 8'd42) begin errors++; $display("FAIL default_value got=%0d want=42", r.bin); end
    checks++; if ({r.inv, r.ovf, r.busy} !== 3'b000) begin errors++; $display("FAIL default_flags got=%b want=000", {r.inv, r.ovf, r.busy}); end
    @(negedge clk);
    r = get_obs(0);
    checks++; if (r.done !== 1'b0) begin errors++; $display("FAIL default_done_pulse got=%b want=0", r.done); end
    checks++; if (r.bin !== 8'd42) begin errors++; $display("FAIL default_hold got=%0d want=42", r.bin); end
    last_bin[0] = 8'd42;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [7:0] held;
    obs_t r;
    do_conv(0, 32'h00, lat, bc, held, r);
    checks++; if (held !== 8'd42) begin errors++; $display("FAIL b2b_hold_at_start got=%0d want=42", held); end
    checks++; if (r.bin !== 8'd0 || lat !== 2) begin errors++; $display("FAIL b2b_first got=%0d lat=%0d want=0 lat=2", r.bin, lat); end
    do_conv(0, 32'h99, lat, bc, held, r);
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_spacing got=%0d want=2", lat); end
    checks++; if (r.bin !== 8'd99 || r.inv !== 1'b0 || r.ovf !== 1'b0) begin
      errors++; $display("FAIL b2b_second got=%0d inv=%b ovf=%b want=99 0 0", r.bin, r.inv, r.ovf);
    end
    last_bin[0] = 8'd99;
  endtask

  task automatic test_invalid;
    int lat, bc;
    logic [7:0] held;
    obs_t r;
    do_conv(0, 32'h3A, lat, bc, held, r);
    checks++; if ({r.inv, r.ovf, r.bin} !== {1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL invalid_3A got inv=%b ovf=%b bin=%0d want 1 0 0", r.inv, r.ovf, r.bin);
    end
    do_conv(0, 32'h07, lat, bc, held, r);
    checks++; if ({r.inv, r.ovf, r.bin} !== {1'b0, 1'b0, 8'd7}) begin
      errors++; $display("FAIL invalid_clear got inv=%b ovf=%b bin=%0d want 0 0 7", r.inv, r.ovf, r.bin);
    end
    last_bin[0] = 8'd7;
  endtask

  task automatic test_overflow;
    int lat, bc;
    logic [7:0] held;
    obs_t r;
    do_conv(1, 32'h99, lat, bc, held, r);
    checks++; if ({r.ovf, r.inv, r.bin} !== {1'b1, 1'b0, 8'd35}) begin
      errors++; $display("FAIL overflow_99 got ovf=%b inv=%b bin=%0d want 1 0 35", r.ovf, r.inv, r.bin);
    end
    do_conv(1, 32'h63, lat, bc, held, r);
    checks++; if ({r.ovf, r.inv, r.bin} !== {1'b0, 1'b0, 8'd63}) begin
      errors++; $display("FAIL overflow_63 got ovf=%b inv=%b bin=%0d want 0 0 63", r.ovf, r.inv, r.bin);
    end
    last_bin[1] = 8'd63;
  endtask

  task automatic test_ignore_start;
    obs_t r;
    int   extra;
    set_in(0, 1'b1, 32'h12);
    @(negedge clk);
    set_in(0, 1'b1, 32'h55);       // start held high during CONVERT, new data
    @(negedge clk);
    r = get_obs(0);
    checks++; if (r.done !== 1'b0 || r.busy !== 1'b1) begin
      errors++; $display("FAIL ignore_mid got done=%b busy=%b want 0 1", r.done, r.busy);
    end
    set_in(0, 1'b0, 32'h77);
    @(negedge clk);
    r = get_obs(0);
    checks++; if (r.done !== 1'b1 || r.bin !== 8'd12) begin
      errors++; $display("FAIL ignore_result got done=%b bin=%0d want 1 12", r.done, r.bin);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      r = get_obs(0);
      if (r.done || r.busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second got=%0d want=0", extra); end
    last_bin[0] = 8'd12;
  endtask

  task automatic test_reset_mid;
    int lat, bc, dones;
    logic [7:0] held;
    obs_t r;
    set_in(0, 1'b1, 32'h42);
    @(negedge clk);
    set_in(0, 1'b0, 32'h0);
    r = get_obs(0);
    checks++; if (r.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b want=1", r.busy); end
    #2 rst_n = 1'b0;
    #1 r = get_obs(0);
    checks++; if (r !== '0) begin errors++; $display("FAIL rstmid_immediate got=%h want=0", r); end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      r = get_obs(0);
      if (r.done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=0", dones); end
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) last_bin[s] = 8'd0;
    do_conv(0, 32'h05, lat, bc, held, r);
    checks++; if (r.bin !== 8'd5 || lat !== 2) begin
      errors++; $display("FAIL rstmid_after got=%0d lat=%0d want=5 lat=2", r.bin, lat);
    end
    last_bin[0] = 8'd5;
  endtask

  task automatic test_single_digit;
    int lat, bc;
    logic [7:0] held;
    obs_t r;
    do_conv(2, 32'h9, lat, bc, held, r);
    checks++; if (lat !== 1 || bc !== 1 || r.bin !== 8'd9 || r.inv !== 1'b0) begin
      errors++; $display("FAIL single_9 got lat=%0d busy=%0d bin=%0d inv=%b want 1 1 9 0", lat, bc, r.bin, r.inv);
    end
    do_conv(2, 32'hF, lat, bc, held, r);
    checks++; if (r.bin !== 8'd0 || r.inv !== 1'b1 || r.ovf !== 1'b0) begin
      errors++; $display("FAIL single_F got bin=%0d inv=%b ovf=%b want 0 1 0", r.bin, r.inv, r.ovf);
    end
    last_bin[2] = 8'd0;
  endtask

  task automatic test_random;
    int lat, bc, sel;
    logic [7:0] held, eb;
    logic [31:0] bcd;
    logic ei, eo;
    obs_t r;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 2));
      bcd = 32'h0;
      for (int k = 0; k < 2; k++) begin
        bcd[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      ref_conv(sel, bcd, eb, ei, eo);
      do_conv(sel, bcd, lat, bc, held, r);
      checks++; if (held !== last_bin[sel]) begin
        errors++; $display("FAIL rand_hold inst=%0d got=%0d want=%0d", sel, held, last_bin[sel]);
      end
      checks++; if (lat !== digs(sel) || bc !== digs(sel)) begin
        errors++; $display("FAIL rand_timing inst=%0d got lat=%0d busy=%0d want %0d", sel, lat, bc, digs(sel));
      end
      checks++; if ({r.bin, r.inv, r.ovf} !== {eb, ei, eo}) begin
        errors++; $display("FAIL rand_result inst=%0d bcd=%h got bin=%0d inv=%b ovf=%b want bin=%0d inv=%b ovf=%b",
                           sel, bcd, r.bin, r.inv, r.ovf, eb, ei, eo);
      end
      last_bin[sel] = eb;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int s = 0; s < 3; s++) last_bin[s] = 8'd0;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_defaults;
    test_back_to_back;
    test_invalid;
    test_overflow;
    test_ignore_start;
    test_reset_mid;
    test_single_digit;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
